register_bank_arbiter: RTL and testbench

Write arbiter and clear sequencer for a file of `DEPTH` `RegisterBank` instances, each `WIDTH` bits wide with a per-register write enable. Up to `NUM_REQ` requesters share the single write path through a valid/ready handshake with round-robin priority. A clear command sequences a zero write into every register, one per cycle. The block sits between the requesting datapath units and the register file and produces each register's `wr_en` and the shared `in` data bus.

---
 rtl/register_bank_arbiter.sv | 139 +++++++++++++
 tb/tb_register_bank_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/register_bank_arbiter.sv
// Round-robin write arbiter and clear sequencer for a file of DEPTH registers.
// Grants one requester per cycle onto the shared registered write path, or zeroes every register in turn.
module register_bank_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 4,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      clr_start,
  output logic                      clr_busy,
  output logic [DEPTH-1:0]          bank_wr_en,
  output logic [WIDTH-1:0]          bank_in,
  output logic [ID_W-1:0]           last_grant
);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [DEPTH-1:0]  wr_en_reg, wr_en_next;
  logic [WIDTH-1:0]  in_reg, in_next;
  logic [ID_W-1:0]   last_grant_reg, last_grant_next;
  logic              busy_reg, busy_next;

  logic                 grant_any;
  logic [ID_W-1:0]      grant_id;
  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [2*NUM_REQ-1:0] valid_rot;
  logic [ADDR_W-1:0]    sel_addr;
  logic [WIDTH-1:0]     sel_data;
  int                   sum;

  // Rotating a doubled copy of req_valid by ptr puts the highest-priority requester at bit 0.
  assign valid_dbl = {req_valid, req_valid};
  assign valid_rot = valid_dbl >> ptr_reg;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    sum       = 0;
    if (state_reg == ARB && !clr_start && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant_any && valid_rot[k]) begin
          grant_any = 1'b1;
          sum       = int'(ptr_reg) + k;
          if (sum >= NUM_REQ) sum = sum - NUM_REQ;
          grant_id  = ID_W'(sum);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_any && grant_id == ID_W'(i)) begin
        req_ready[i] = 1'b1;
        sel_addr     = req_addr[i*ADDR_W +: ADDR_W];
        sel_data     = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    cnt_next        = cnt_reg;
    wr_en_next      = '0;
    in_next         = '0;
    last_grant_next = last_grant_reg;
    busy_next       = 1'b0;
    case (state_reg)
      ARB: begin
        if (clr_start) begin
          state_next    = CLEAR;
          wr_en_next[0] = 1'b1;
          busy_next     = 1'b1;
          cnt_next      = ADDR_W'(1);
        end else if (grant_any) begin
          // Out-of-range addresses decode to no enable, so the write is silently dropped.
          for (int d = 0; d < DEPTH; d++)
            wr_en_next[d] = (sel_addr == ADDR_W'(d));
          in_next         = sel_data;
          last_grant_next = grant_id;
          ptr_next        = (int'(grant_id) == NUM_REQ-1) ? '0 : grant_id + 1'b1;
        end
      end
      CLEAR: begin
        for (int d = 0; d < DEPTH; d++)
          wr_en_next[d] = (cnt_reg == ADDR_W'(d));
        busy_next = 1'b1;
        // Return to ARB as the last clear write issues so a grant can follow with no bubble.
        if (cnt_reg == ADDR_W'(DEPTH-1)) begin
          state_next = ARB;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ARB;
      ptr_reg        <= '0;
      cnt_reg        <= '0;
      wr_en_reg      <= '0;
      in_reg         <= '0;
      last_grant_reg <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      cnt_reg        <= cnt_next;
      wr_en_reg      <= wr_en_next;
      in_reg         <= in_next;
      last_grant_reg <= last_grant_next;
      busy_reg       <= busy_next;
    end
  end

  assign bank_wr_en = wr_en_reg;
  assign bank_in    = in_reg;
  assign last_grant = last_grant_reg;
  assign clr_busy   = busy_reg;

endmodule

// File: tb/tb_register_bank_arbiter.sv
// Directed bench for register_bank_arbiter driving a 4-entry register bank model.
// Covers reset, single write, round-robin order, pointer fairness, clear, and reset mid-clear.
module tb_register_bank_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [7:0]  req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        clr_start;
  logic        clr_busy;
  logic [3:0]  bank_wr_en;
  logic [7:0]  bank_in;
  logic [1:0]  last_grant;

  logic [7:0]  bank_q [4];
  int          n_assert = 0;
  int          n_fail = 0;

  register_bank_arbiter #(.WIDTH(8), .NUM_REQ(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .clr_start(clr_start),
    .clr_busy(clr_busy), .bank_wr_en(bank_wr_en), .bank_in(bank_in),
    .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  // Four RegisterBank stand-ins, reset together with the arbiter.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) bank_q[i] <= 8'h00;
      else if (bank_wr_en[i]) bank_q[i] <= bank_in;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] a, input logic [7:0] d);
    req_valid[i]       = v;
    req_addr[i*2 +: 2] = a;
    req_data[i*8 +: 8] = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; clr_start = 1'b0;
    req_valid = 4'hF; req_addr = '0; req_data = '0;
    #1;
    chk("rst_ready_pre", 32'(req_ready), 32'h0);
    tick;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wr_en", 32'(bank_wr_en), 32'h0);
    chk("rst_bank_in", 32'(bank_in), 32'h0);
    chk("rst_busy", 32'(clr_busy), 32'h0);
    chk("rst_last_grant", 32'(last_grant), 32'h0);
    rst = 1'b0; req_valid = 4'h0;

    // Single write: requester 1 -> register 2.
    set_req(1, 1'b1, 2'd2, 8'hA5);
    #1 chk("single_ready", 32'(req_ready), 32'h2);
    tick;
    chk("single_wr_en", 32'(bank_wr_en), 32'h4);
    chk("single_bank_in", 32'(bank_in), 32'hA5);
    chk("single_last_grant", 32'(last_grant), 32'h1);
    req_valid = 4'h0;
    tick;
    chk("single_wr_idle", 32'(bank_wr_en), 32'h0);
    chk("single_reg2", 32'(bank_q[2]), 32'hA5);

    // Re-reset so the round-robin starts from ptr=0.
    rst = 1'b1; tick; rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'(i), 8'(8'h10 + i));
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick;
      chk("rr_last_grant", 32'(last_grant), 32'(k % 4));
      chk("rr_wr_en", 32'(bank_wr_en), 32'(4'b0001 << (k % 4)));
      chk("rr_bank_in", 32'(bank_in), 32'(8'h10 + (k % 4)));
    end
    req_valid = 4'h0;
    tick;
    chk("rr_regs", {bank_q[3], bank_q[2], bank_q[1], bank_q[0]}, 32'h13121110);

    // Fairness: ptr=1 now; grant 2, then with 0 and 3 pending 3 wins before 0.
    set_req(2, 1'b1, 2'd2, 8'hFF);
    #1 chk("fair_ready2", 32'(req_ready), 32'h4);
    tick;
    chk("fair_grant2", 32'(last_grant), 32'h2);
    req_valid = 4'h0;
    set_req(0, 1'b1, 2'd0, 8'hFF);
    set_req(3, 1'b1, 2'd3, 8'hFF);
    #1 chk("fair_ready3", 32'(req_ready), 32'h8);
    tick;
    chk("fair_grant3", 32'(last_grant), 32'h3);
    req_valid[3] = 1'b0;
    #1 chk("fair_ready0", 32'(req_ready), 32'h1);
    tick;
    chk("fair_grant0", 32'(last_grant), 32'h0);
    req_valid = 4'h0;
    set_req(1, 1'b1, 2'd1, 8'hFF);
    tick;
    req_valid = 4'h0;
    tick;
    chk("fill_regs", {bank_q[3], bank_q[2], bank_q[1], bank_q[0]}, 32'hFFFFFFFF);

    // Clear while requester 0 is pending; ptr=2 so requester 0 is still the only candidate.
    set_req(0, 1'b1, 2'd0, 8'h5A);
    clr_start = 1'b1;
    #1 chk("clr_start_ready", 32'(req_ready), 32'h0);
    tick;
    clr_start = 1'b0;
    chk("clr_busy0", 32'(clr_busy), 32'h1);
    chk("clr_wr_en0", 32'(bank_wr_en), 32'h1);
    chk("clr_bank_in0", 32'(bank_in), 32'h0);
    #1 chk("clr_ready_blocked", 32'(req_ready), 32'h0);
    for (int k = 1; k < 4; k++) begin
      tick;
      chk("clr_busy", 32'(clr_busy), 32'h1);
      chk("clr_wr_en", 32'(bank_wr_en), 32'(4'b0001 << k));
      chk("clr_bank_in", 32'(bank_in), 32'h0);
    end
    #1 chk("clr_first_grant_ready", 32'(req_ready), 32'h1);
    tick;
    chk("clr_busy_fall", 32'(clr_busy), 32'h0);
    chk("clr_regs_zero", {bank_q[3], bank_q[2], bank_q[1], bank_q[0]}, 32'h0);
    chk("post_clr_wr_en", 32'(bank_wr_en), 32'h1);
    chk("post_clr_bank_in", 32'(bank_in), 32'h5A);
    chk("post_clr_last_grant", 32'(last_grant), 32'h0);
    req_valid = 4'h0;
    tick;
    chk("post_clr_reg0", 32'(bank_q[0]), 32'h5A);

    // Reset at the edge ending the second clear cycle.
    clr_start = 1'b1;
    tick;
    clr_start = 1'b0;
    tick;
    chk("mid_clr_wr_en1", 32'(bank_wr_en), 32'h2);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'(i), 8'(8'h40 + i));
    #1 chk("mid_rst_ready", 32'(req_ready), 32'h0);
    tick;
    chk("mid_rst_wr_en", 32'(bank_wr_en), 32'h0);
    chk("mid_rst_busy", 32'(clr_busy), 32'h0);
    chk("mid_rst_regs", {bank_q[3], bank_q[2], bank_q[1], bank_q[0]}, 32'h0);
    rst = 1'b0;
    req_valid = 4'h0;
    for (int k = 0; k < 2; k++) begin
      tick;
      chk("after_rst_wr_en", 32'(bank_wr_en), 32'h0);
      chk("after_rst_busy", 32'(clr_busy), 32'h0);
    end
    chk("after_rst_regs", {bank_q[3], bank_q[2], bank_q[1], bank_q[0]}, 32'h0);
    req_valid = 4'hF;
    #1 chk("after_rst_ready", 32'(req_ready), 32'h1);
    tick;
    chk("after_rst_grant", 32'(last_grant), 32'h0);
    chk("after_rst_bank_in", 32'(bank_in), 32'h40);
    req_valid = 4'h0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
